lfo_tremolo: RTL and testbench

//  Consumes the three 8-bit sine LFO outputs (fast/mid/slow) and applies amplitude modulation to a

---
 rtl/lfo_tremolo.sv | 115 +++++++++++
 tb/tb_lfo_tremolo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfo_tremolo.sv
// Tremolo: scales a signed sample stream by an LFO-derived gain through a 2-stage valid/ready pipeline.
// Optional TREMOLO_PEAK_EN adds a clearable peak-magnitude tracker on the output.
module lfo_tremolo #(
  parameter int unsigned DW = 16,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [LW-1:0] lfo_fast,
  input  logic [LW-1:0] lfo_mid,
  input  logic [LW-1:0] lfo_slow,
  input  logic [1:0]    rate_sel,
  input  logic [7:0]    depth,
  input  logic [DW-1:0] in_sample,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_sample,
  output logic          out_valid,
  input  logic          out_ready
`ifdef TREMOLO_PEAK_EN
  ,
  input  logic          peak_clr,
  output logic [DW-2:0] peak_level
`endif
);

  localparam int unsigned GW       = LW + 1;
  localparam int unsigned PW       = LW + 8;
  localparam int unsigned LFO_MAX  = (1 << LW) - 1;
  localparam int unsigned GAIN_ONE = 1 << LW;

  logic          s1_valid;
  logic [DW-1:0] s1_sample;
  logic [GW-1:0] s1_gain;
  logic          s2_en;
  logic          s1_load;
  logic [LW-1:0] lfo_sel;
  logic [PW-1:0] mod_prod;
  logic [GW-1:0] gain_c;
  logic signed [DW+GW:0] mult;

  // Output stage frees up when empty or being drained; input accepted when stage 1 can move.
  always_comb begin
    s2_en    = !out_valid || out_ready;
    in_ready = !s1_valid || s2_en;
    s1_load  = in_valid && in_ready;
  end

  // Gain from the selected LFO; bypass forces unity.
  always_comb begin
    lfo_sel = lfo_fast;
    case (rate_sel)
      2'd1:    lfo_sel = lfo_mid;
      2'd2:    lfo_sel = lfo_slow;
      default: lfo_sel = lfo_fast;
    endcase
    mod_prod = PW'(depth) * PW'(LW'(LFO_MAX) - lfo_sel);
    gain_c   = GW'(GAIN_ONE) - GW'(mod_prod >> 8);
    if (rate_sel == 2'd3) begin
      gain_c = GW'(GAIN_ONE);
    end
  end

  assign mult = $signed(s1_sample) * $signed({1'b0, s1_gain});

  // Stage 1: capture sample and gain at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sample <= '0;
      s1_gain   <= '0;
    end else if (in_ready) begin
      s1_valid <= s1_load;
      if (s1_load) begin
        s1_sample <= in_sample;
        s1_gain   <= gain_c;
      end
    end
  end

  // Stage 2: scaled output, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sample <= DW'(mult >>> LW);
      end
    end
  end

`ifdef TREMOLO_PEAK_EN
  logic [DW-1:0] mag_full;
  logic [DW-2:0] mag;

  // |out_sample| with the most negative value clamped to the positive maximum.
  always_comb begin
    mag_full = out_sample[DW-1] ? (DW'(0) - out_sample) : out_sample;
    mag      = mag_full[DW-1] ? '1 : mag_full[DW-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (peak_clr) begin
      peak_level <= '0;
    end else if (out_valid && out_ready && (mag > peak_level)) begin
      peak_level <= mag;
    end
  end
`endif

endmodule

// File: tb/tb_lfo_tremolo.sv
// Bench for lfo_tremolo: arithmetic reference queue checked every cycle plus literal directed checks.
// Build with TREMOLO_PEAK_EN defined to also exercise the peak tracker.
module tb_lfo_tremolo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  lfo_fast, lfo_mid, lfo_slow;
  logic [1:0]  rate_sel;
  logic [7:0]  depth;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready;
`ifdef TREMOLO_PEAK_EN
  logic        peak_clr;
  logic [14:0] peak_level;
`endif

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  lfo_tremolo dut (
    .clk(clk), .rst_n(rst_n),
    .lfo_fast(lfo_fast), .lfo_mid(lfo_mid), .lfo_slow(lfo_slow),
    .rate_sel(rate_sel), .depth(depth),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready)
`ifdef TREMOLO_PEAK_EN
    , .peak_clr(peak_clr), .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: gain from the formula, then floor(sample*gain/256).
  function automatic int model(input logic [15:0] s, input logic [1:0] r, input logic [7:0] d,
                               input logic [7:0] f, input logic [7:0] m, input logic [7:0] sl);
    int lfo, g, sv;
    lfo = (r == 2'd0) ? int'(f) : (r == 2'd1) ? int'(m) : int'(sl);
    g   = (r == 2'd3) ? 256 : 256 - (int'(d) * (255 - lfo)) / 256;
    sv  = int'($signed(s));
    return (sv * g) >>> 8;
  endfunction

  // Per-cycle compare against the reference queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
      chk("rst_out_sample", out_sample, 16'h0);
    end else begin
      if (exp_q.size() == 0) chk("idle_out_valid", {15'b0, out_valid}, 16'h0);
      else if (out_valid) chk("out_data", out_sample, 16'(exp_q[0]));
      chk("in_ready", {15'b0, in_ready}, {15'b0, (exp_q.size() < 2) || out_ready});
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sample, rate_sel, depth, lfo_fast, lfo_mid, lfo_slow));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input logic [1:0] r, input logic [7:0] d,
                      input logic [7:0] f, input logic [7:0] m, input logic [7:0] sl);
    int n;
    in_sample = s; rate_sel = r; depth = d;
    lfo_fast = f; lfo_mid = m; lfo_slow = sl;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      out_ready = 1'b1;
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 16'h0, 16'h1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
    rate_sel = '0; depth = '0; lfo_fast = '0; lfo_mid = '0; lfo_slow = '0;
`ifdef TREMOLO_PEAK_EN
    peak_clr = 1'b0;
`endif
    step(); step();
    chk("reset_in_ready", {15'b0, in_ready}, 16'h1);
    rst_n = 1'b1;
    step();

    // depth 0 passes through; valid two cycles after the accept cycle
    send(16'h1234, 2'd0, 8'd0, 8'd77, 8'd0, 8'd0);
    chk("t1_latency_early", {15'b0, out_valid}, 16'h0);
    step();
    chk("t1_latency_valid", {15'b0, out_valid}, 16'h1);
    chk("t1_data", out_sample, 16'h1234);
    drain();

    send(16'h4000, 2'd0, 8'd255, 8'd0, 8'd200, 8'd200);
    step();
    chk("t2_min_gain", out_sample, 16'h0080);
    drain();

    send(16'hFF00, 2'd1, 8'd128, 8'd0, 8'd128, 8'd0);
    step();
    chk("t3_neg_floor", out_sample, 16'hFF3F);
    drain();

    send(16'h8000, 2'd3, 8'd255, 8'd0, 8'd0, 8'd0);
    step();
    chk("t4_bypass", out_sample, 16'h8000);
    drain();

    // backpressure: two held, third blocked
    out_ready = 1'b0;
    send(16'h0101, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    send(16'h0202, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    in_sample = 16'h0303; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_in_ready_low", {15'b0, in_ready}, 16'h0);
      chk("t5_hold", out_sample, 16'h0101);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_shift_a", out_sample, 16'h0202);
    step();
    chk("t5_shift_b", out_sample, 16'h0303);
    drain();

    // reset mid-stream
    out_ready = 1'b0;
    send(16'h1111, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    send(16'h2222, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_cleared", {15'b0, out_valid}, 16'h0);
    chk("t6_sample_cleared", out_sample, 16'h0);
    chk("t6_in_ready", {15'b0, in_ready}, 16'h1);
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    send(16'h7FFF, 2'd2, 8'd64, 8'd0, 8'd0, 8'd255);
    drain();

    // mixed vectors with a stuttering sink
    for (int i = 0; i < 24; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(16'($urandom), 2'(i % 4), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain();

`ifdef TREMOLO_PEAK_EN
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("peak_cleared", {1'b0, peak_level}, 16'h0);
    send(16'h0100, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    send(16'hFD00, 2'd3, 8'd0, 8'd0, 8'd0, 8'd0);
    drain();
    step();
    chk("peak_level", {1'b0, peak_level}, 16'h0300);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
